freq_sweep_ctrl: RTL

Sequencer that drives the 32-bit `freq_set` word of the phase-accumulator clock divider through a programmed frequency sweep. It steps from a start frequency to a stop frequency in fixed increments and holds each point for a programmable number of clock cycles. A start/busy/done handshake frames each sweep, and abort may cut it short. The block sits between the control/register logic and the divider, and is the sole driver of the divider's `freq_set`.

---
 rtl/freq_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl
// Drives the 32-bit freq_set word of the phase-accumulator divider through a
// programmed sweep. It runs from f_start to f_stop in f_step increments and
// holds each point for max(dwell,1) cycles. Both endpoints are clamped to
// FMAX = CLKREF/2.
//
// Optional feature: define FREQ_SWEEP_PINGPONG_EN to sweep back to f_start
// after f_stop. The turnaround point is held only once.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      sweep request (IDLE only) / terminate (any state)
//   f_start, f_stop   sweep endpoints in Hz (latched at start)
//   f_step, dwell     step magnitude in Hz, cycles per point (latched)
//   freq_set          frequency word to the divider
//   freq_valid, busy  sweep active flags
//   done, step_stb    completion pulse / new-point pulse
//   dbg_state_o       current FSM state, for observation only
//
// Handshake: start is sampled on a rising edge while in IDLE with abort low.
// busy rises after that edge and stays high until the edge that enters DONE
// or takes abort. done pulses for one cycle on normal completion only.
module freq_sweep_ctrl #(
    parameter logic [31:0] CLKREF = 32'd256_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] f_start,
    input  logic [31:0] f_stop,
    input  logic [31:0] f_step,
    input  logic [31:0] dwell,
    output logic [31:0] freq_set,
    output logic        freq_valid,
    output logic        busy,
    output logic        done,
    output logic        step_stb,
    output logic [1:0]  dbg_state_o
);

    localparam logic [31:0] FMAX = CLKREF >> 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] freq_q, freq_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] step_q, step_d;
    logic [31:0] end_q, end_d;
    logic        up_q, up_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        stb_q, stb_d;
`ifdef FREQ_SWEEP_PINGPONG_EN
    logic [31:0] home_q, home_d;   // clamped f_start, target of the return leg
    logic        ret_q, ret_d;     // set once the return leg has begun
`endif

    logic [31:0] fs_clamped;
    logic [31:0] fe_clamped;

    assign fs_clamped = (f_start > FMAX) ? FMAX : f_start;
    assign fe_clamped = (f_stop  > FMAX) ? FMAX : f_stop;

    // One step from cur toward tgt in 33-bit arithmetic. Overshoot, overflow
    // or underflow all saturate to tgt, and a zero step jumps straight there.
    function automatic logic [31:0] next_point(input logic [31:0] cur,
                                               input logic [31:0] step,
                                               input logic [31:0] tgt,
                                               input logic        up);
        logic [32:0] res;
        logic [31:0] pt;
        if (up) begin
            res = {1'b0, cur} + {1'b0, step};
            pt  = (res[32] || res[31:0] > tgt) ? tgt : res[31:0];
        end else begin
            res = {1'b0, cur} - {1'b0, step};
            pt  = (res[32] || res[31:0] < tgt) ? tgt : res[31:0];
        end
        if (step == 32'd0) begin
            pt = tgt;
        end
        return pt;
    endfunction

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        step_d   = step_q;
        end_d    = end_q;
        up_d     = up_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        stb_d    = 1'b0;
`ifdef FREQ_SWEEP_PINGPONG_EN
        home_d   = home_q;
        ret_d    = ret_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    step_d   = f_step;
                    end_d    = fe_clamped;
                    up_d     = (fe_clamped >= fs_clamped);
                    reload_d = (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
                    cnt_d    = (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
                    freq_d   = fs_clamped;
                    busy_d   = 1'b1;
                    valid_d  = 1'b1;
                    stb_d    = 1'b1;
                    state_d  = S_DWELL;
`ifdef FREQ_SWEEP_PINGPONG_EN
                    home_d   = fs_clamped;
                    ret_d    = 1'b0;
`endif
                end
            end

            S_DWELL: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (freq_q == end_q) begin
`ifdef FREQ_SWEEP_PINGPONG_EN
                    // Turn around at f_stop unless the sweep is a single point.
                    if (!ret_q && (home_q != end_q)) begin
                        ret_d  = 1'b1;
                        end_d  = home_q;
                        up_d   = ~up_q;
                        freq_d = next_point(freq_q, step_q, home_q, ~up_q);
                        cnt_d  = reload_q;
                        stb_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                    end
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
`endif
                end else begin
                    freq_d = next_point(freq_q, step_q, end_q, up_q);
                    cnt_d  = reload_q;
                    stb_d  = 1'b1;
                end
            end

            S_DONE: begin
                // start in this cycle is deliberately dropped.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_d = S_IDLE;
            freq_d  = 32'd0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            freq_q   <= 32'd0;
            cnt_q    <= 32'd0;
            reload_q <= 32'd0;
            step_q   <= 32'd0;
            end_q    <= 32'd0;
            up_q     <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            stb_q    <= 1'b0;
`ifdef FREQ_SWEEP_PINGPONG_EN
            home_q   <= 32'd0;
            ret_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            step_q   <= step_d;
            end_q    <= end_d;
            up_q     <= up_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            stb_q    <= stb_d;
`ifdef FREQ_SWEEP_PINGPONG_EN
            home_q   <= home_d;
            ret_q    <= ret_d;
`endif
        end
    end

    assign freq_set    = freq_q;
    assign freq_valid  = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_stb    = stb_q;
    assign dbg_state_o = state_q;

endmodule
